cnn_linebuffer_win: RTL

- Parametrised streaming line buffer for the conv front end.
- Accepts one pixel per handshake in raster order and stores the last K-1 image lines in K-1 line RAMs.
- For each accepted pixel, emits a K-tall vertical column (current pixel plus the pixels directly above it).
- Flags when the column completes a full KxK window, so the downstream window/MAC stage can assemble windows by shifting columns.

---
 rtl/cnn_linebuffer_win_pkg.sv | 7 +
 rtl/cnn_lb_ram.sv | 22 ++
 rtl/cnn_linebuffer_win.sv | 92 +++++++++
 3 files changed

// File: rtl/cnn_linebuffer_win_pkg.sv
// cnn_linebuffer_win_pkg: shared pixel width default and counter-width helper
package cnn_linebuffer_win_pkg;
  localparam int CNN_DATA_IN_W = 8;
  function automatic int lb_cw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cnn_lb_ram.sv
// cnn_lb_ram: single-clock dual-port line RAM with registered, enable-gated read
module cnn_lb_ram
  import cnn_linebuffer_win_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 25,
  parameter int AW = lb_cw(DEPTH)
) (
  input  logic          clk,
  input  logic          w_en,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  input  logic          r_en,
  input  logic [AW-1:0] r_addr,
  output logic [DW-1:0] r_data
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
    if (r_en) r_data <= mem[r_addr];
  end
endmodule

// File: rtl/cnn_linebuffer_win.sv
// cnn_linebuffer_win: K-line streaming buffer emitting K-tall pixel columns; CNN_LB_SOF_EN adds in_sof/err_sof
module cnn_linebuffer_win
  import cnn_linebuffer_win_pkg::*;
#(
  parameter int DW = CNN_DATA_IN_W,
  parameter int IMG_W = 25,
  parameter int IMG_H = 25,
  parameter int K = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
`ifdef CNN_LB_SOF_EN
  input  logic          in_sof,
  output logic          err_sof,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K*DW-1:0] out_col,
  output logic          out_win_valid,
  output logic          out_eol,
  output logic          out_eof
);
  localparam int cw = lb_cw(IMG_W);
  localparam int rw = lb_cw(IMG_H);
  localparam logic [cw-1:0] col_last = cw'(IMG_W - 1);
  localparam logic [rw-1:0] row_last = rw'(IMG_H - 1);
  logic accept, sof, wb_v, last_col;
  logic [cw-1:0] col_cnt, col_e, col_q;
  logic [rw-1:0] row_cnt, row_e, row_q;
  logic [DW-1:0] pix_q;
  logic [DW-1:0] rd [K-1];
  assign in_ready = !out_valid | out_ready;
  assign accept = in_valid & in_ready;
`ifdef CNN_LB_SOF_EN
  assign sof = in_sof;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_sof <= 1'b0;
    else if (accept & in_sof & ((col_cnt != '0) | (row_cnt != '0))) err_sof <= 1'b1;
`else
  assign sof = 1'b0;
`endif
  assign col_e = sof ? '0 : col_cnt;
  assign row_e = sof ? '0 : row_cnt;
  assign last_col = col_e == col_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      col_q <= '0;
      row_q <= '0;
      pix_q <= '0;
      wb_v <= 1'b0;
      out_valid <= 1'b0;
      out_win_valid <= 1'b0;
      out_eol <= 1'b0;
      out_eof <= 1'b0;
    end else begin
      wb_v <= accept;
      out_valid <= accept | (out_valid & !out_ready);
      if (accept) begin
        col_cnt <= last_col ? '0 : col_e + 1'b1;
        row_cnt <= !last_col ? row_e : (row_e == row_last) ? '0 : row_e + 1'b1;
        col_q <= col_e;
        row_q <= row_e;
        pix_q <= in_data;
        out_win_valid <= (row_e >= rw'(K - 1)) & (col_e >= cw'(K - 1));
        out_eol <= last_col;
        out_eof <= last_col & (row_e == row_last);
      end
    end
  // writeback shifts each column down one line: RAM g+1 takes what RAM g held
  for (genvar g = 0; g < K - 1; g++) begin : g_ram
    cnn_lb_ram #(.DW(DW), .DEPTH(IMG_W), .AW(cw)) u_ram (
      .clk    (clk),
      .w_en   (wb_v),
      .w_addr (col_q),
      .w_data ((g == 0) ? pix_q : rd[(g == 0) ? 0 : g - 1]),
      .r_en   (accept),
      .r_addr (col_e),
      .r_data (rd[g])
    );
  end
  // lines above the current row that do not exist yet in this frame read as 0
  always_comb begin
    out_col = '0;
    out_col[DW-1:0] = pix_q;
    for (int i = 1; i < K; i++) out_col[i*DW +: DW] = (int'(row_q) >= i) ? rd[i-1] : '0;
  end
endmodule
